// File: rtl/neopixel_pkg.sv
// neopixel_pkg: color encodings, receiver states and nominal NeoPixel timing shared with the strand controller
package neopixel_pkg;
    typedef enum logic [1:0] {RED = 2'b00, BLUE = 2'b01, GREEN = 2'b10} color_e;
    typedef enum logic [2:0] {SYNC, ARMED, HIGH, LOW, ERROR} rx_state_e;
    localparam int BITS_PER_PIXEL = 24;
    localparam int T1H = 36;
    localparam int T1L = 30;
    localparam int T0H = 19;
    localparam int T0L = 40;
    localparam int LATCH_CLKS = 1250;
endpackage

// File: rtl/neo_pixel_strand_receiver_meter.sv
// neo_pulse_meter: synchronizes neo_in, flags edges and measures the current high/low run lengths
module neo_pulse_meter #(
    parameter int MAX_HIGH  = 50,
    parameter int LATCH_LOW = 1250,
    parameter int LW        = $clog2(LATCH_LOW + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          neo_in,
    output logic          rise,
    output logic          fall,
    output logic [6:0]    high_len,
    output logic [LW-1:0] low_len
);
    localparam logic [6:0]    H_SAT = 7'(MAX_HIGH + 1);
    localparam logic [LW-1:0] L_SAT = LW'(LATCH_LOW);
    logic [2:0] sync;
    // run lengths count completed cycles of the current level, so on the edge cycle they hold the full pulse width
    always_ff @(posedge clock) begin
        if (reset) begin
            sync     <= '0;
            high_len <= '0;
            low_len  <= '0;
        end else begin
            sync     <= {sync[1:0], neo_in};
            high_len <= !sync[1] ? '0 : high_len == H_SAT ? high_len : high_len + 7'd1;
            low_len  <= sync[1] ? '0 : low_len == L_SAT ? low_len : low_len + LW'(1);
        end
    end
    assign rise = sync[1] & ~sync[2];
    assign fall = ~sync[1] & sync[2];
endmodule

// File: rtl/neo_pixel_strand_receiver.sv
// neo_pixel_strand_receiver: decodes the NeoPixel serial stream into a committed per-pixel G/R/B display buffer
module neo_pixel_strand_receiver
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS    = 5,
    parameter int BIT_THRESHOLD = 27,
    parameter int MIN_HIGH      = 8,
    parameter int MAX_HIGH      = 50,
    parameter int LATCH_LOW     = LATCH_CLKS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       neo_in,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    output logic [7:0] color_level,
    output logic       frame_done,
    output logic       frame_error,
    output logic       busy
);
    localparam int NBITS = NUM_PIXELS * BITS_PER_PIXEL;
    localparam int LW    = $clog2(LATCH_LOW + 1);
    localparam int IW    = $clog2(NBITS + 1);
    localparam logic [LW-1:0] LATCH = LW'(LATCH_LOW);
    localparam logic [IW-1:0] FULL  = IW'(NBITS);
    localparam logic [6:0]    H_MIN = 7'(MIN_HIGH);
    localparam logic [6:0]    H_MAX = 7'(MAX_HIGH);
    localparam logic [6:0]    H_ONE = 7'(BIT_THRESHOLD);
    localparam logic [2:0]    NP    = 3'(NUM_PIXELS);
    rx_state_e state, state_next;
    logic rise, fall, start, write_bit, commit, set_err;
    logic [6:0] high_len;
    logic [LW-1:0] low_len;
    logic [IW-1:0] bit_idx;
    logic [NBITS-1:0] work;
    logic [NUM_PIXELS-1:0][BITS_PER_PIXEL-1:0] disp;
    logic [BITS_PER_PIXEL-1:0] pix;

    neo_pulse_meter #(.MAX_HIGH(MAX_HIGH), .LATCH_LOW(LATCH_LOW), .LW(LW)) meter (
        .clock(clock), .reset(reset), .neo_in(neo_in),
        .rise(rise), .fall(fall), .high_len(high_len), .low_len(low_len)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= SYNC;
        else state <= state_next;
    end

    // a nonzero high run in ARMED means the rising edge coincided with the latch and must still start a packet
    always_comb begin
        state_next = state;
        start      = 1'b0;
        write_bit  = 1'b0;
        commit     = 1'b0;
        set_err    = 1'b0;
        case (state)
            ARMED: begin
                start      = rise || high_len != '0;
                state_next = start ? HIGH : ARMED;
            end
            HIGH: if (fall) begin
                set_err    = high_len < H_MIN || high_len > H_MAX || bit_idx == FULL;
                write_bit  = !set_err;
                state_next = set_err ? ERROR : LOW;
            end
            LOW: if (low_len == LATCH) begin
                commit     = bit_idx == FULL;
                set_err    = !commit;
                state_next = ARMED;
            end else if (rise) state_next = HIGH;
            default: if (low_len == LATCH) state_next = ARMED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_idx     <= '0;
            work        <= '0;
            disp        <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_done <= commit;
            if (start) begin
                bit_idx     <= '0;
                frame_error <= 1'b0;
            end
            if (write_bit) begin
                work[bit_idx] <= high_len >= H_ONE;
                bit_idx       <= bit_idx + IW'(1);
            end
            if (commit) disp <= work;
            if (set_err) frame_error <= 1'b1;
        end
    end

    assign busy        = state == HIGH || state == LOW;
    assign pix         = disp[pixel_index];
    assign color_level = pixel_index >= NP ? 8'd0 :
                         color_index == RED   ? pix[15:8] :
                         color_index == BLUE  ? pix[7:0] :
                         color_index == GREEN ? pix[23:16] : 8'd0;
endmodule
